// File: rtl/serial_edge_scheduler.sv
// rtl/serial_edge_scheduler.sv - word serializer feeding a falling-edge Mealy detector with edge counting
//
// Accepts a WIDTH-bit word on the in_* handshake and drives it one bit per
// cycle into a two-state 1->0 detector. After the word, one zero flush cycle
// is appended. The number of detector pulses (saturating at 2^CNT_W-1) is then
// offered on the out_* handshake.
//
// Build option: define SER_SCHED_LSB_FIRST_EN to serialize LSB first
// (default is MSB first).
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_valid/in_ready    word handshake, in_data carries the word
//   abort                cancels the word in flight (SHIFT/FLUSH only)
//   out_valid/out_ready  result handshake, out_count carries the edge count
//   ser_x, det_y         serial bit and detector output (observation)
//   busy                 high while in SHIFT or FLUSH
module serial_edge_scheduler #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count,
  output logic             ser_x,
  output logic             det_y,
  output logic             busy
);

  localparam int IDX_W = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [1:0]       state;
  logic [WIDTH-1:0] sreg;
  logic [IDX_W-1:0] idx;
  logic             det_state;  // previous ser_x, the detector's only state bit
  logic [CNT_W-1:0] cnt;
  logic             ser_bit;
  logic [WIDTH-1:0] sreg_next;

`ifdef SER_SCHED_LSB_FIRST_EN
  assign ser_bit   = sreg[0];
  assign sreg_next = {1'b0, sreg[WIDTH-1:1]};
`else
  assign ser_bit   = sreg[WIDTH-1];
  assign sreg_next = {sreg[WIDTH-2:0], 1'b0};
`endif

  assign busy      = (state == S_SHIFT) || (state == S_FLUSH);
  // FLUSH, IDLE and DONE all drive zero; only SHIFT exposes the word.
  assign ser_x     = (state == S_SHIFT) ? ser_bit : 1'b0;
  // Gated by busy so a stale detector state left by an abort cannot pulse in IDLE.
  assign det_y     = busy & det_state & ~ser_x;
  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign out_count = cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      sreg      <= '0;
      idx       <= '0;
      det_state <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            sreg      <= in_data;
            idx       <= '0;
            cnt       <= '0;
            det_state <= 1'b0;
            state     <= S_SHIFT;
          end
        end
        S_SHIFT, S_FLUSH: begin
          if (abort) begin
            cnt       <= '0;
            det_state <= 1'b0;
            state     <= S_IDLE;
          end else begin
            det_state <= ser_x;
            if (det_y && (cnt != CNT_MAX)) begin
              cnt <= cnt + CNT_W'(1);
            end
            if (state == S_SHIFT) begin
              sreg <= sreg_next;
              idx  <= idx + IDX_W'(1);
              if (idx == LAST_IDX) begin
                state <= S_FLUSH;
              end
            end else begin
              state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_edge_scheduler.sv
// tb/tb_serial_edge_scheduler.sv - directed table-driven bench for serial_edge_scheduler
//
// Two instances share all inputs: dut (WIDTH=8, CNT_W=4) and dut_sat
// (WIDTH=8, CNT_W=2) for the saturation case. Expected det_y patterns follow
// SER_SCHED_LSB_FIRST_EN when it is defined.
module tb_serial_edge_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       abort;
  logic       out_ready;

  logic       in_ready, out_valid, ser_x, det_y, busy;
  logic [3:0] out_count;
  logic       s_in_ready, s_out_valid, s_ser_x, s_det_y, s_busy;
  logic [1:0] s_out_count;

  int n_vec = 0;
  int n_bad = 0;

`ifdef SER_SCHED_LSB_FIRST_EN
  localparam bit LSB_FIRST = 1'b1;
`else
  localparam bit LSB_FIRST = 1'b0;
`endif

  always #5 clk = ~clk;

  serial_edge_scheduler #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .abort(abort), .out_valid(out_valid),
    .out_ready(out_ready), .out_count(out_count), .ser_x(ser_x),
    .det_y(det_y), .busy(busy)
  );

  serial_edge_scheduler #(.WIDTH(8), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_data(in_data), .abort(abort), .out_valid(s_out_valid),
    .out_ready(out_ready), .out_count(s_out_count), .ser_x(s_ser_x),
    .det_y(s_det_y), .busy(s_busy)
  );

  // mask bit j = det_y in cycle T+1+j (j=8 is the flush cycle)
  typedef struct {
    logic [7:0] data;
    logic [8:0] mask_msb;
    logic [8:0] mask_lsb;
    logic [3:0] cnt;
    logic [1:0] sat;
    int         hold;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic run_word(input vec_t v);
    logic [8:0] dmask, bmask, rmask, xmask, exp_x;
    dmask = '0; bmask = '0; rmask = '0; xmask = '0;
    for (int j = 0; j < 8; j++) exp_x[j] = LSB_FIRST ? v.data[j] : v.data[7-j];
    exp_x[8] = 1'b0;
    wait_ready();
    out_ready = (v.hold == 0);
    in_valid  = 1'b1;
    in_data   = v.data;
    @(negedge clk);                  // cycle T+1
    in_valid = 1'b0;
    for (int j = 0; j < 9; j++) begin
      dmask[j] = det_y;
      bmask[j] = busy;
      rmask[j] = in_ready | out_valid;
      xmask[j] = ser_x;
      @(negedge clk);
    end
    // cycle T+10: first DONE cycle
    chk($sformatf("det_y_%02h", v.data), 32'(dmask), 32'(LSB_FIRST ? v.mask_lsb : v.mask_msb));
    chk($sformatf("ser_x_%02h", v.data), 32'(xmask), 32'(exp_x));
    chk($sformatf("busy_%02h", v.data), 32'(bmask), 32'h1FF);
    chk($sformatf("rdy_vld_low_%02h", v.data), 32'(rmask), 32'h0);
    chk($sformatf("out_valid_%02h", v.data), 32'(out_valid), 32'd1);
    chk($sformatf("out_count_%02h", v.data), 32'(out_count), 32'(v.cnt));
    chk($sformatf("sat_count_%02h", v.data), 32'(s_out_count), 32'(v.sat));
    if (v.hold > 0) begin
      in_valid = 1'b1;
      in_data  = 8'h3C;
      for (int h = 0; h < v.hold; h++) begin
        chk($sformatf("hold_valid_%0d", h), 32'(out_valid), 32'd1);
        chk($sformatf("hold_count_%0d", h), 32'(out_count), 32'(v.cnt));
        chk($sformatf("hold_in_ready_%0d", h), 32'(in_ready), 32'd0);
        @(negedge clk);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
    end else begin
      @(negedge clk);
    end
    chk($sformatf("idle_ready_%02h", v.data), 32'(in_ready), 32'd1);
    chk($sformatf("idle_valid_%02h", v.data), 32'(out_valid), 32'd0);
    chk($sformatf("idle_count_%02h", v.data), 32'(out_count), 32'(v.cnt));
  endtask

  initial begin
    vecs[0] = '{8'hAA, 9'h0AA, 9'h154, 4'd4, 2'd3, 0};
    vecs[1] = '{8'h00, 9'h000, 9'h000, 4'd0, 2'd0, 0};
    vecs[2] = '{8'hFF, 9'h100, 9'h100, 4'd1, 2'd1, 0};
    vecs[3] = '{8'h01, 9'h100, 9'h002, 4'd1, 2'd1, 0};
    vecs[4] = '{8'h55, 9'h154, 9'h0AA, 4'd4, 2'd3, 5};
    vecs[5] = '{8'h0F, 9'h100, 9'h010, 4'd1, 2'd1, 0};
    vecs[6] = '{8'h80, 9'h002, 9'h100, 4'd1, 2'd1, 0};
    vecs[7] = '{8'hC3, 9'h104, 9'h104, 4'd2, 2'd2, 0};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; abort = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_count", 32'(out_count), 32'd0);
    chk("rst_ser_x", 32'(ser_x), 32'd0);
    chk("rst_det_y", 32'(det_y), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // reset mid-SHIFT after one edge has been counted
    in_valid = 1'b1; in_data = 8'hAA;
    @(negedge clk);                  // T+1
    in_valid = 1'b0;
    @(negedge clk);                  // T+2
    @(negedge clk);                  // T+3, count already 1
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_count", 32'(out_count), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 8; i++) run_word(vecs[i]);

    // abort at T+4 with 8'hAA
    wait_ready();
    in_valid = 1'b1; in_data = 8'hAA;
    @(negedge clk);                  // T+1
    in_valid = 1'b0;
    @(negedge clk);                  // T+2
    @(negedge clk);                  // T+3
    @(negedge clk);                  // T+4
    abort = 1'b1;
    @(negedge clk);                  // T+5
    abort = 1'b0;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_count", 32'(out_count), 32'd0);
    chk("abort_det_y", 32'(det_y), 32'd0);
    begin
      logic seen_valid;
      seen_valid = 1'b0;
      for (int k = 0; k < 12; k++) begin
        seen_valid = seen_valid | out_valid;
        @(negedge clk);
      end
      chk("abort_no_out_valid", 32'(seen_valid), 32'd0);
    end
    run_word(vecs[5]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_edge_scheduler.md
# serial_edge_scheduler

Controller that accepts parallel words over a valid/ready handshake and serializes each word, one bit per cycle, into an embedded two-state falling-edge (1→0) Mealy detector. It counts the detector's output pulses over the word plus one flush cycle, then reports the count through a second valid/ready handshake. It sits between a word-oriented producer and the serial detection datapath, owning the detector's sequencing, clearing and result collection.

## Interface
- WIDTH, 8, bits per input word (≥2)
- CNT_W, 4, width of the edge counter and of out_count (≥1)
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  producer has a word on in_data
- in_ready  output  1  block accepts a word this cycle
- in_data  input  WIDTH  word to serialize
- abort  input  1  synchronous cancel of the word in flight
- out_valid  output  1  out_count is valid
- out_ready  input  1  consumer accepts out_count
- out_count  output  CNT_W  number of 1→0 transitions detected
- ser_x  output  1  serial bit currently driven into the detector (observation)
- det_y  output  1  detector Mealy output this cycle (observation)
- busy  output  1  high in SHIFT or FLUSH

## Operation
- States: IDLE, SHIFT, FLUSH, DONE. Reset state: IDLE.
- IDLE: in_ready=1. When in_valid&in_ready, capture in_data into a shift register, clear bit index, clear edge counter, and clear the detector state to "last bit 0". → SHIFT.
- SHIFT: ser_x = current bit (MSB first by default). Shift by one per cycle. After bit WIDTH-1 → FLUSH.
- FLUSH: ser_x=0 for exactly one cycle, so a trailing 1 registers as an edge. → DONE.
- DONE: out_valid=1; out_count is stable. When out_ready → IDLE. out_ready low holds DONE indefinitely.
- Detector: state bit = previous ser_x. det_y = state & ~ser_x (combinational, Mealy). Detector state updates from ser_x every SHIFT/FLUSH cycle and holds otherwise.
- Counter: increments on each clock edge where det_y=1. Saturates at 2^CNT_W−1 and does not wrap.
- abort: sampled in SHIFT or FLUSH only. Forces → IDLE next cycle and clears the counter. No out_valid is produced. abort is ignored in IDLE and DONE.
- ser_x=0 and det_y=0 in IDLE and DONE.
- Reset values: in_ready=1, out_valid=0, out_count=0, ser_x=0, det_y=0, busy=0. Reset mid-word discards the word without producing a result.

## Timing
- Handshake at edge T. SHIFT covers cycles T+1..T+WIDTH. FLUSH is cycle T+WIDTH+1. out_valid rises in cycle T+WIDTH+2.
- Minimum word-to-word period is WIDTH+3 cycles, reached when out_ready=1 in the first DONE cycle.
- in_ready is low from T+1 until the cycle after the out handshake. There is no overlap of input and output handshakes.
- An edge on bit k (ser_x=1 at bit k−1, 0 at bit k) is counted at the end of cycle T+1+k.
- out_count updates on the output handshake only via the next load. It holds its value in IDLE until the next accepted word clears it.

## Configuration
- SER_SCHED_LSB_FIRST_EN defined: bits are serialized LSB first (in_data[0] at T+1).
- Undefined (default): MSB first (in_data[WIDTH-1] at T+1).
- All other behaviour and timing are identical.

## Test plan
- Reset then idle: rst pulsed mid-SHIFT → next cycle in_ready=1, out_valid=0, out_count=0, busy=0.
- in_data=8'hAA, MSB-first, out_ready=1 → det_y pulses at T+2/4/6/8, out_valid at T+10 with out_count=4; 8'h00 → 0; 8'hFF → 1 (flush cycle T+9).
- 8'h01 MSB-first → single det_y at T+9 (flush), count=1. With SER_SCHED_LSB_FIRST_EN → det_y at T+2, count=1.
- Backpressure: 8'h55 (count=4), out_ready low for 5 cycles → out_valid and out_count=4 held, in_ready=0, in_valid ignored. out_ready high → IDLE next cycle.
- abort asserted at T+4 with 8'hAA → IDLE at T+5, no out_valid. A following word 8'h0F → count=1.
- Saturation: CNT_W=2, WIDTH=8, 8'hAA → out_count=3, no wrap.
